load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Parametrised load/store unit between the MEM stage and the data bus. It places
//  byte/half/word data on the correct lanes, sign/zero-extends load data and handshakes
//  with the memory on separate request/response channels. Misaligned accesses are either
//  split into two bus beats or trapped. Bus hangs are caught by a response timeout.
//  It supersedes the combinational access decoder. mem_stall holds the pipeline until resp_valid.
// PARAMETERS
//  XLEN            32  data/address width; 32 or 64 (BYTES = XLEN/8, OFS_W = log2(BYTES))
//  MISALIGN_SPLIT  1   1: split line-crossing access into 2 beats; 0: raise misaligned fault
//  TIMEOUT         255 max cycles waiting for mem_rvalid before access fault (>=1)
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous reset, active-high
//  req_valid         in   1      MEM stage presents an access
//  req_ready         out  1      unit can accept (high only in IDLE)
//  access_type       in   4      common:: SB,SH,SW,LB,LBU,LH,LHU,LW; other = no access
//  addr              in   XLEN   byte address
//  wdata             in   XLEN   store data, LSB-aligned
//  resp_valid        out  1      1-cycle pulse: access finished (ok or fault)
//  rdata             out  XLEN   extended load data (0 for stores/faults)
//  mem_stall         out  1      req_valid & mem-type access & !resp_valid
//  load_misaligned   out  1      valid with resp_valid
//  store_misaligned  out  1      valid with resp_valid
//  load_access       out  1      load access fault (mem_err or timeout), valid with resp_valid
//  store_access      out  1      store access fault, valid with resp_valid
//  mem_req_valid     out  1      bus request valid
//  mem_req_ready     in   1      bus accepts request
//  mem_addr          out  XLEN   BYTES-aligned beat address
//  mem_we            out  1      1 = write beat
//  mem_strb          out  BYTES  byte enables
//  mem_wdata         out  XLEN   lane-shifted write data
//  mem_rvalid        in   1      bus response (read data or write ack)
//  mem_rdata         in   XLEN   read data
//  mem_err           in   1      bus error with mem_rvalid
// BEHAVIOUR
//  - Reset (sync, rst=1): state IDLE; all outputs 0 except req_ready=1; timer=0. Reset
//    mid-access abandons it: mem_req_valid drops the cycle after rst, no resp_valid.
//  - Size: B=1, H=2, W=4 bytes. ofs=addr[OFS_W-1:0]. Misaligned when ofs % size != 0.
//    Crossing when ofs+size > BYTES. Natural misalignment within a beat needs no split.
//  - FSM: IDLE -> REQ0 -> RSP0 -> [REQ1 -> RSP1] -> DONE -> IDLE.
//    IDLE: if req_valid & valid type, latch type/addr/wdata. Misaligned & MISALIGN_SPLIT=0
//      -> DONE with *_misaligned, no bus traffic. Else -> REQ0. Non-mem type: stay in IDLE.
//    REQx: mem_req_valid=1 with stable addr/we/strb/wdata until mem_req_ready; -> RSPx.
//    RSPx: wait mem_rvalid; timer counts from 0, at timer==TIMEOUT -> DONE with access fault.
//      mem_err -> DONE with access fault; beat1 is skipped. A store beat0 already written
//      is not rolled back. RSP0 ok & crossing -> REQ1, else -> DONE. Timer clears per beat.
//    DONE: resp_valid=1 for exactly one cycle, faults/rdata valid; -> IDLE.
//  - Beat0: mem_addr=addr&~(BYTES-1); strb=(base_strb<<ofs)[BYTES-1:0];
//    wdata=wdata<<(8*ofs). Beat1: mem_addr=beat0+BYTES; strb=base_strb>>(BYTES-ofs);
//    wdata=wdata>>(8*(BYTES-ofs)). base_strb: B=1, H=3, W=F (hex).
//  - Load assembly: {beat1_data,beat0_data}>>(8*ofs), mask to size; LB/LH/LW sign-extend
//    to XLEN (LW sign-extends only when XLEN=64); LBU/LHU zero-extend.
//  - Latency with zero-wait bus: aligned access resp_valid 3 cycles after acceptance;
//    split +2. mem_rvalid outside RSPx is ignored. req_ready=0 outside IDLE.
// TESTING
//  - LB addr=0x1003, mem_rdata=0x80FFFFFF, zero wait -> strb=1000, resp at +3, rdata=0xFFFFFF80
//  - LHU addr=0x2002, mem_rdata=0xBEEF1234 -> strb=1100, rdata=0x0000BEEF, no fault
//  - SW addr=0x3001 wdata=0xAABBCCDD, SPLIT=1 -> beat0 0x3000 strb=1110 wdata=BBCCDD00;
//    beat1 0x3004 strb=0001 wdata=000000AA; resp at +5
//  - SH addr=0x3003, SPLIT=0 -> no mem_req_valid, resp_valid+store_misaligned at +1
//  - LW addr=0x4000, mem_req_ready=1, never mem_rvalid, TIMEOUT=4 -> load_access with resp
//  - rst asserted in RSP0 -> next cycle IDLE, req_ready=1, mem_req_valid=0, no resp_valid

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit sitting between the MEM stage and a request/response data bus.
// It steers store data onto byte lanes, assembles and extends load data, and
// either splits line-crossing accesses into two beats or traps them. A bounded
// response wait turns a silent bus into an access fault.

package common;
  typedef enum logic [3:0] {
    ACC_NONE = 4'h0,
    SB       = 4'h1,
    SH       = 4'h2,
    SW       = 4'h3,
    LB       = 4'h4,
    LBU      = 4'h5,
    LH       = 4'h6,
    LHU      = 4'h7,
    LW       = 4'h8
  } access_t;

  typedef struct packed {
    logic       valid;  // access_type names a memory access
    logic       load;   // 1 = load, 0 = store
    logic       sext;   // sign-extend load data
    logic [2:0] size;   // bytes: 1, 2 or 4
  } acc_info_t;

  function automatic acc_info_t decode_access(input logic [3:0] t);
    acc_info_t d;
    d = '0;
    case (t)
      SB:      d = '{valid: 1'b1, load: 1'b0, sext: 1'b0, size: 3'd1};
      SH:      d = '{valid: 1'b1, load: 1'b0, sext: 1'b0, size: 3'd2};
      SW:      d = '{valid: 1'b1, load: 1'b0, sext: 1'b0, size: 3'd4};
      LB:      d = '{valid: 1'b1, load: 1'b1, sext: 1'b1, size: 3'd1};
      LBU:     d = '{valid: 1'b1, load: 1'b1, sext: 1'b0, size: 3'd1};
      LH:      d = '{valid: 1'b1, load: 1'b1, sext: 1'b1, size: 3'd2};
      LHU:     d = '{valid: 1'b1, load: 1'b1, sext: 1'b0, size: 3'd2};
      // Sign extension of a word only has visible effect when XLEN is 64.
      LW:      d = '{valid: 1'b1, load: 1'b1, sext: 1'b1, size: 3'd4};
      default: d = '0;
    endcase
    return d;
  endfunction
endpackage

module load_store_unit #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        access_type,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   rdata,
  output logic              mem_stall,
  output logic              load_misaligned,
  output logic              store_misaligned,
  output logic              load_access,
  output logic              store_access,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_strb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);
  import common::*;

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE
  } state_t;

  state_t          state, state_nx;
  acc_info_t       in_info, acc_q;
  logic [XLEN-1:0] addr_q, wdata_q, beat0_q, beat1_q;
  logic [TMR_W-1:0] timer;
  logic            fault_mis_q, fault_acc_q;

  logic            accept, in_misaligned, crossing, timed_out, in_beat1;
  logic [3:0]      in_ofs, in_size, ofs4, size4;
  int              ofs_int;
  logic [BYTES-1:0] strb_base;
  logic [XLEN-1:0] beat_base;
  logic [2*XLEN-1:0] load_shift;
  logic [XLEN-1:0] load_data;
  logic            sign_bit;

  // Decode of the incoming request, used only while IDLE.
  assign in_info       = decode_access(access_type);
  assign in_ofs        = 4'(addr[OFS_W-1:0]);
  assign in_size       = {1'b0, in_info.size};
  assign in_misaligned = (in_ofs & (in_size - 4'd1)) != 4'd0;
  assign accept        = (state == S_IDLE) && req_valid && in_info.valid;

  // Geometry of the latched access.
  assign ofs4      = 4'(addr_q[OFS_W-1:0]);
  assign size4     = {1'b0, acc_q.size};
  assign ofs_int   = int'(ofs4);
  assign crossing  = (ofs4 + size4) > 4'(BYTES);
  assign timed_out = (timer == TMR_W'(TIMEOUT));
  assign in_beat1  = (state == S_REQ1);
  assign beat_base = {addr_q[XLEN-1:OFS_W], {OFS_W{1'b0}}};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers are assigned with <= so every flop samples the pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic for the access sequence.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept)
                state_nx = (in_misaligned && !MISALIGN_SPLIT) ? S_DONE : S_REQ0;
      S_REQ0: if (mem_req_ready) state_nx = S_RSP0;
      S_RSP0: if (mem_rvalid)     state_nx = (!mem_err && crossing) ? S_REQ1 : S_DONE;
              else if (timed_out) state_nx = S_DONE;
      S_REQ1: if (mem_req_ready) state_nx = S_RSP1;
      S_RSP1: if (mem_rvalid || timed_out) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Access capture, per-beat response timer, read data and fault capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat0_q     <= '0;
      beat1_q     <= '0;
      timer       <= '0;
      fault_mis_q <= 1'b0;
      fault_acc_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          acc_q       <= in_info;
          addr_q      <= addr;
          wdata_q     <= wdata;
          beat0_q     <= '0;
          beat1_q     <= '0;
          timer       <= '0;
          fault_mis_q <= in_misaligned && !MISALIGN_SPLIT;
          fault_acc_q <= 1'b0;
        end
        S_REQ0, S_REQ1: timer <= '0;
        S_RSP0, S_RSP1: begin
          if (mem_rvalid) begin
            if (state == S_RSP0) beat0_q <= mem_rdata;
            else                 beat1_q <= mem_rdata;
            fault_acc_q <= mem_err;
          end else if (timed_out) begin
            fault_acc_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-enable pattern of the access before lane shifting.
  always_comb begin
    strb_base = '0;
    case (acc_q.size)
      3'd1:    strb_base[0]   = 1'b1;
      3'd2:    strb_base[1:0] = 2'b11;
      default: strb_base[3:0] = 4'hF;
    endcase
  end

  // Load assembly: align the two beats, then zero- or sign-extend from the access size.
  always_comb begin
    load_shift = {beat1_q, beat0_q} >> (8 * ofs_int);
    case (acc_q.size)
      3'd1:    sign_bit = load_shift[7];
      3'd2:    sign_bit = load_shift[15];
      default: sign_bit = load_shift[31];
    endcase
    sign_bit  = sign_bit & acc_q.sext;
    load_data = load_shift[XLEN-1:0];
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(acc_q.size)) load_data[i] = sign_bit;
    end
  end

  // Bus request channel: beat 0 carries the low lanes, beat 1 the spill-over.
  assign mem_req_valid = (state == S_REQ0) || (state == S_REQ1);
  assign mem_we        = mem_req_valid && !acc_q.load;
  assign mem_addr      = !mem_req_valid ? '0 :
                         in_beat1 ? beat_base + XLEN'(BYTES) : beat_base;
  assign mem_strb      = !mem_req_valid ? '0 :
                         in_beat1 ? strb_base >> (BYTES - ofs_int) : strb_base << ofs4;
  assign mem_wdata     = !mem_we ? '0 :
                         in_beat1 ? wdata_q >> (8 * (BYTES - ofs_int)) : wdata_q << (8 * ofs_int);

  // Pipeline-facing response.
  assign req_ready        = (state == S_IDLE);
  assign resp_valid       = (state == S_DONE);
  assign load_misaligned  = resp_valid && fault_mis_q &&  acc_q.load;
  assign store_misaligned = resp_valid && fault_mis_q && !acc_q.load;
  assign load_access      = resp_valid && fault_acc_q &&  acc_q.load;
  assign store_access     = resp_valid && fault_acc_q && !acc_q.load;
  assign rdata            = (resp_valid && acc_q.valid && acc_q.load && !fault_mis_q && !fault_acc_q)
                            ? load_data : '0;
  assign mem_stall        = req_valid && in_info.valid && !resp_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance splits misaligned accesses
// (short response timeout), a second traps them.
module tb_load_store_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_t;
  logic [3:0]  access_type;
  logic [31:0] addr, wdata;
  logic        mem_req_ready, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, mem_stall, load_misaligned, store_misaligned;
  logic        load_access, store_access, mem_req_valid, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_strb;

  logic        t_req_ready, t_resp_valid, t_mem_stall, t_load_mis, t_store_mis;
  logic        t_load_acc, t_store_acc, t_mem_req_valid, t_mem_we;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .access_type(access_type), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .mem_stall(mem_stall),
    .load_misaligned(load_misaligned), .store_misaligned(store_misaligned),
    .load_access(load_access), .store_access(store_access),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0), .TIMEOUT(4)) u_trap (
    .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_ready(t_req_ready),
    .access_type(access_type), .addr(addr), .wdata(wdata),
    .resp_valid(t_resp_valid), .rdata(t_rdata), .mem_stall(t_mem_stall),
    .load_misaligned(t_load_mis), .store_misaligned(t_store_mis),
    .load_access(t_load_acc), .store_access(t_store_acc),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(1'b1),
    .mem_addr(t_mem_addr), .mem_we(t_mem_we), .mem_strb(t_mem_strb), .mem_wdata(t_mem_wdata),
    .mem_rvalid(1'b0), .mem_rdata(32'h0), .mem_err(1'b0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus model: 0 = respond next cycle, 1 = respond with error on beat err_beat, 2 = never respond.
  int          bus_mode = 0;
  int          err_beat = 0;
  int          n_beats  = 0;
  logic [31:0] rd_beat [2];
  logic [31:0] log_addr [4];
  logic [31:0] log_wdata[4];
  logic [3:0]  log_strb [4];
  logic        log_we   [4];

  initial begin
    int idx;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready && !rst) begin
        idx = n_beats;
        if (idx < 4) begin
          log_addr[idx]  = mem_addr;
          log_wdata[idx] = mem_wdata;
          log_strb[idx]  = mem_strb;
          log_we[idx]    = mem_we;
        end
        n_beats++;
        @(posedge clk);
        #1;
        if (bus_mode != 2) begin
          mem_rvalid = 1'b1;
          mem_err    = (bus_mode == 1) && (idx == err_beat);
          mem_rdata  = (idx < 2) ? rd_beat[idx] : 32'h0;
          @(posedge clk);
          #1;
          mem_rvalid = 1'b0;
          mem_err    = 1'b0;
          mem_rdata  = '0;
        end
      end
    end
  end

  // Captured response of the last access.
  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_lm, r_sm, r_la, r_sa, r_stall, r_saw_req;

  task automatic run_access(input bit trap, input logic [3:0] t, input logic [31:0] a,
                            input logic [31:0] wd);
    n_beats   = 0;
    r_lat     = -1;
    r_saw_req = 1'b0;
    @(posedge clk);
    #1;
    access_type = t;
    addr        = a;
    wdata       = wd;
    if (trap) req_valid_t = 1'b1;
    else      req_valid   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (trap && t_mem_req_valid) r_saw_req = 1'b1;
      if (n == 0) begin
        check("ready_at_accept", trap ? t_req_ready : req_ready, 1'b1);
        check("stall_at_accept", trap ? t_mem_stall : mem_stall, 1'b1);
      end
      if (n == 1) check("ready_busy", trap ? t_req_ready : req_ready, 1'b0);
      if (trap ? t_resp_valid : resp_valid) begin
        r_lat   = n;
        r_rdata = trap ? t_rdata : rdata;
        r_lm    = trap ? t_load_mis : load_misaligned;
        r_sm    = trap ? t_store_mis : store_misaligned;
        r_la    = trap ? t_load_acc : load_access;
        r_sa    = trap ? t_store_acc : store_access;
        r_stall = trap ? t_mem_stall : mem_stall;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_valid_t = 1'b0;
    access_type = ACC_NONE;
  endtask

  task automatic check_resp(input string tag, input int lat, input logic [31:0] rd,
                            input logic [3:0] faults);
    check({tag, "_lat"},   r_lat, lat);
    check({tag, "_rdata"}, r_rdata, rd);
    check({tag, "_fault"}, {r_lm, r_sm, r_la, r_sa}, faults);
    check({tag, "_stall"}, r_stall, 1'b0);
  endtask

  initial begin
    int seen;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_valid_t = 1'b0;
    access_type = ACC_NONE;
    addr        = '0;
    wdata       = '0;
    mem_req_ready = 1'b1;
    rd_beat[0]  = '0;
    rd_beat[1]  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_strb", mem_strb, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LB, top byte of the word, negative.
    bus_mode = 0; rd_beat[0] = 32'h80FF_FFFF;
    run_access(1'b0, LB, 32'h1003, 32'h0);
    check_resp("lb", 3, 32'hFFFF_FF80, 4'b0000);
    check("lb_beats", n_beats, 1);
    check("lb_addr", log_addr[0], 32'h1000);
    check("lb_strb", log_strb[0], 4'b1000);
    check("lb_we", log_we[0], 1'b0);

    // LHU, upper half, zero-extended.
    rd_beat[0] = 32'hBEEF_1234;
    run_access(1'b0, LHU, 32'h2002, 32'h0);
    check_resp("lhu", 3, 32'h0000_BEEF, 4'b0000);
    check("lhu_strb", log_strb[0], 4'b1100);

    // LH naturally misaligned inside one beat: no split.
    rd_beat[0] = 32'h00FF_8000;
    run_access(1'b0, LH, 32'h7001, 32'h0);
    check_resp("lh_in", 3, 32'hFFFF_FF80, 4'b0000);
    check("lh_in_beats", n_beats, 1);
    check("lh_in_strb", log_strb[0], 4'b0110);

    // SW crossing a word: two beats.
    run_access(1'b0, SW, 32'h3001, 32'hAABB_CCDD);
    check_resp("sw_split", 5, 32'h0, 4'b0000);
    check("sw_beats", n_beats, 2);
    check("sw_b0_addr", log_addr[0], 32'h3000);
    check("sw_b0_strb", log_strb[0], 4'b1110);
    check("sw_b0_wdata", log_wdata[0], 32'hBBCC_DD00);
    check("sw_b0_we", log_we[0], 1'b1);
    check("sw_b1_addr", log_addr[1], 32'h3004);
    check("sw_b1_strb", log_strb[1], 4'b0001);
    check("sw_b1_wdata", log_wdata[1], 32'h0000_00AA);

    // LW crossing: bytes 2..5 of the two beats.
    rd_beat[0] = 32'h4433_2211; rd_beat[1] = 32'h8877_6655;
    run_access(1'b0, LW, 32'h5002, 32'h0);
    check_resp("lw_split", 5, 32'h6655_4433, 4'b0000);
    check("lw_b1_addr", log_addr[1], 32'h5004);
    check("lw_b1_strb", log_strb[1], 4'b0011);

    // LH crossing from the last byte, sign-extended.
    rd_beat[0] = 32'h1234_5678; rd_beat[1] = 32'h9ABC_DEF0;
    run_access(1'b0, LH, 32'h6003, 32'h0);
    check_resp("lh_split", 5, 32'hFFFF_F012, 4'b0000);
    check("lh_b0_strb", log_strb[0], 4'b1000);
    check("lh_b1_strb", log_strb[1], 4'b0001);

    // Silent bus: timeout after TIMEOUT+1 response cycles.
    bus_mode = 2;
    run_access(1'b0, LW, 32'h4000, 32'h0);
    check_resp("lw_timeout", 7, 32'h0, 4'b0010);

    // Bus error on an aligned load.
    bus_mode = 1; err_beat = 0; rd_beat[0] = 32'hDEAD_BEEF;
    run_access(1'b0, LW, 32'h8000, 32'h0);
    check_resp("lw_err", 3, 32'h0, 4'b0010);

    // Bus error on the first beat of a split store: second beat skipped.
    run_access(1'b0, SW, 32'h9002, 32'h1122_3344);
    check_resp("sw_err", 3, 32'h0, 4'b0001);
    check("sw_err_beats", n_beats, 1);

    // Non-memory access type: no stall, no bus traffic, no response.
    bus_mode = 0;
    @(posedge clk); #1;
    access_type = 4'hF; addr = 32'h100; req_valid = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_req_valid || !req_ready || mem_stall) seen++;
    end
    check("nonmem_idle", seen, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; access_type = ACC_NONE;

    // Reset while waiting in RSP0 abandons the access.
    bus_mode = 2; n_beats = 0;
    @(posedge clk); #1;
    access_type = LW; addr = 32'h4000; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; access_type = ACC_NONE;
    @(negedge clk);
    check("rstmid_req0", mem_req_valid, 1'b1);
    @(negedge clk);
    check("rstmid_rsp0_ready", req_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", req_ready, 1'b1);
    check("rstmid_mem_req_valid", mem_req_valid, 1'b0);
    seen = 0;
    repeat (8) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("rstmid_no_resp", seen, 0);
    bus_mode = 0;

    // Trapping instance: misaligned accesses fault immediately with no bus traffic.
    run_access(1'b1, SH, 32'h3003, 32'h0000_1234);
    check_resp("trap_sh", 1, 32'h0, 4'b0100);
    check("trap_sh_no_bus", r_saw_req, 1'b0);
    run_access(1'b1, LW, 32'h4002, 32'h0);
    check_resp("trap_lw", 1, 32'h0, 4'b1000);
    check("trap_lw_no_bus", r_saw_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
